button_debouncer: RTL and testbench



---
 rtl/button_debouncer_pkg.sv | 29 ++
 rtl/button_debouncer_channel.sv | 100 ++++++++++
 rtl/button_debouncer.sv | 70 +++++++
 tb/tb_button_debouncer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared types and elaboration helpers for the button debouncer
// Contents:
//    deb_state_e  : per-channel FSM state (ST_STABLE / ST_SETTLING)
//    clog2        : counter width helper, never returns less than 1
//    tick_cycles  : prescaler period in clk cycles from clock rate and tick period
package button_debouncer_pkg;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } deb_state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

   function automatic int tick_cycles(input int clk_freq_hz, input int tick_us);
      return (clk_freq_hz / 1000000) * tick_us;
   endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// rtl/button_debouncer_channel.sv - one debounce channel: synchroniser, settle FSM, output and pulses
// Ports:
//    clk, reset_n    : clock, asynchronous active-low reset
//    button_in       : raw asynchronous switch level
//    tick            : shared prescaler strobe
//    button_out      : debounced level (registered)
//    press_pulse     : one-cycle strobe when the pressed level is accepted
//    release_pulse   : one-cycle strobe when the released level is accepted
module button_debouncer_channel
   import button_debouncer_pkg::*;
#(
   parameter int   STABLE_TICKS = 10,
   parameter logic RELEASED     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic button_in,
   input  logic tick,
   output logic button_out,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int CW = clog2(STABLE_TICKS + 1);

   logic          sync1_q, sync1_d;
   logic          sync_q, sync_d;
   deb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          mismatch;

   always_comb begin
      sync1_d   = button_in;
      sync_d    = sync1_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      mismatch  = (sync_q != out_q);

      case (state_q)
         ST_STABLE: begin
            cnt_d = '0;
            if (mismatch) begin
               state_d = ST_SETTLING;
            end
         end
         ST_SETTLING: begin
            // A return to the accepted level beats a coincident tick.
            if (!mismatch) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (tick) begin
               if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                  out_d     = sync_q;
                  press_d   = (sync_q != RELEASED);
                  release_d = (sync_q == RELEASED);
                  cnt_d     = '0;
                  state_d   = ST_STABLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= RELEASED;
         sync_q    <= RELEASED;
         state_q   <= ST_STABLE;
         cnt_q     <= '0;
         out_q     <= RELEASED;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign button_out    = out_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel push-button debouncer with shared prescaler
// Ports:
//    clk, reset_n    : clock, asynchronous active-low reset
//    button_in       : raw asynchronous switch levels, one bit per channel
//    button_out      : debounced levels, feeds the PIO in_port
//    press_pulse     : per-channel one-cycle strobe on accepted press
//    release_pulse   : per-channel one-cycle strobe on accepted release
//    tick            : registered prescaler strobe, one cycle every TICK_CYCLES
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int NUM_BUTTONS  = 4,
   parameter int CLK_FREQ_HZ  = 50000000,
   parameter int TICK_US      = 1000,
   parameter int STABLE_TICKS = 10,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_BUTTONS-1:0] button_in,
   output logic [NUM_BUTTONS-1:0] button_out,
   output logic [NUM_BUTTONS-1:0] press_pulse,
   output logic [NUM_BUTTONS-1:0] release_pulse,
   output logic                   tick
);

   localparam int   TICK_CYCLES = tick_cycles(CLK_FREQ_HZ, TICK_US);
   localparam int   PW          = clog2(TICK_CYCLES);
   localparam logic RELEASED    = (ACTIVE_LOW != 0);

   logic [PW-1:0] presc_q, presc_d;
   logic          tick_q, tick_d;

   always_comb begin
      presc_d = presc_q + PW'(1);
      tick_d  = 1'b0;
      if (presc_q == PW'(TICK_CYCLES - 1)) begin
         presc_d = '0;
         tick_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      button_debouncer_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .RELEASED     (RELEASED)
      ) u_chan (
         .clk           (clk),
         .reset_n       (reset_n),
         .button_in     (button_in[i]),
         .tick          (tick_q),
         .button_out    (button_out[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - scoreboard bench for button_debouncer
module tb_button_debouncer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] button_in = 4'b0000;
   logic [3:0] button_out;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic       tick;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] out;
      int         t0;
      int         lo;
      int         hi;
      string      name;
   } exp_t;

   exp_t sb[$];

   button_debouncer #(
      .NUM_BUTTONS  (4),
      .CLK_FREQ_HZ  (1000000),
      .TICK_US      (4),
      .STABLE_TICKS (3),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .button_in     (button_in),
      .button_out    (button_out),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .tick          (tick)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string name, input logic [3:0] p, input logic [3:0] r,
                       input logic [3:0] o, input int lo, input int hi);
      exp_t e;
      e.press = p;
      e.rel   = r;
      e.out   = o;
      e.t0    = cyc;
      e.lo    = lo;
      e.hi    = hi;
      e.name  = name;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout actual=%0d pending expected=0 pending", name, sb.size());
         sb.delete();
      end
      step(4);
   endtask

   // Monitor: every cycle with any pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (reset_n && ((press_pulse | release_pulse) != 4'b0000)) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse actual press=%b release=%b expected none",
                     press_pulse, release_pulse);
         end else begin
            exp_t e;
            int   lat;
            e   = sb.pop_front();
            lat = cyc - e.t0;
            chk({e.name, "_press"}, press_pulse, e.press);
            chk({e.name, "_release"}, release_pulse, e.rel);
            chk({e.name, "_out"}, button_out, e.out);
            n_tests++;
            if (lat < e.lo || lat > e.hi) begin
               n_fail++;
               $display("FAIL %s_latency actual=%0d expected=%0d..%0d", e.name, lat, e.lo, e.hi);
            end
         end
      end
   end

   initial begin
      int ticks;

      // Reset with all buttons held down.
      step(3);
      chk("reset_out", button_out, 4'b1111);
      chk("reset_press", press_pulse, 4'b0000);
      chk("reset_release", release_pulse, 4'b0000);
      chk("reset_tick", {3'b000, tick}, 4'b0000);
      reset_n = 1'b1;
      push("held_through_reset", 4'b1111, 4'b0000, 4'b0000, 11, 15);
      drain("held_through_reset");

      // Release everything.
      button_in = 4'b1111;
      push("release_all", 4'b0000, 4'b1111, 4'b1111, 11, 15);
      drain("release_all");

      // Clean press on channel 0.
      button_in = 4'b1110;
      push("clean_press", 4'b0001, 4'b0000, 4'b1110, 11, 15);
      drain("clean_press");

      // Bounce on channel 1, then a firm hold.
      for (int k = 0; k < 10; k++) begin
         button_in[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
         step(3);
      end
      chk("bounce_no_change", button_out, 4'b1110);
      button_in[1] = 1'b0;
      push("bounce_press", 4'b0010, 4'b0000, 4'b1100, 11, 15);
      drain("bounce_press");

      // Short glitches on channel 2 must be rejected.
      button_in[2] = 1'b0;
      step(1);
      button_in[2] = 1'b1;
      step(20);
      button_in[2] = 1'b0;
      step(7);
      button_in[2] = 1'b1;
      step(30);
      chk("glitch_out", button_out, 4'b1100);

      // Channel 3 press and channel 0 release in the same cycle.
      button_in = 4'b0101;
      push("simultaneous", 4'b1000, 4'b0001, 4'b0101, 11, 15);
      drain("simultaneous");

      // Release channel 1, then reset in the middle of its next settle window.
      button_in = 4'b0111;
      push("release_ch1", 4'b0000, 4'b0010, 4'b0111, 11, 15);
      drain("release_ch1");
      button_in = 4'b0101;
      step(9);
      reset_n = 1'b0;
      #1;
      chk("midreset_out", button_out, 4'b1111);
      chk("midreset_press", press_pulse, 4'b0000);
      chk("midreset_release", release_pulse, 4'b0000);
      step(3);
      reset_n = 1'b1;
      push("requalify", 4'b1010, 4'b0000, 4'b0101, 11, 15);
      drain("requalify");

      // Prescaler period: one tick every 4 cycles.
      ticks = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tick) ticks++;
      end
      n_tests++;
      if (ticks != 10) begin
         n_fail++;
         $display("FAIL tick_count actual=%0d expected=10", ticks);
      end

      step(20);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_events actual=%0d expected=0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
